// File: rtl/shifter_pkg.sv
// Shared definitions for the iterative shifter.
//   state_t      : FSM states (IDLE, SHIFT, DONE)
//   MODE_*       : encodings of the two-bit mode input; 2'b11 falls back to logical
package shifter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [1:0] MODE_LOGICAL = 2'b00;
  localparam logic [1:0] MODE_ROTATE  = 2'b01;
  localparam logic [1:0] MODE_ARITH   = 2'b10;

endpackage

// File: rtl/digit_expand.sv
// Expands each result bit into a 4-bit display digit {3'b000, bit}.
// Ports:
//   i_bits   [WIDTH-1:0]   value to display
//   o_digits [4*WIDTH-1:0] digit i occupies bits [4i+3:4i]
module digit_expand #(
  parameter int WIDTH = 6
) (
  input  logic [WIDTH-1:0]   i_bits,
  output logic [4*WIDTH-1:0] o_digits
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_digit
    assign o_digits[4*i +: 4] = {3'b000, i_bits[i]};
  end

endmodule

// File: rtl/iter_shifter.sv
// Iterative shifter: shifts an operand one bit per clock for shamt cycles.
// Supports logical, rotate and arithmetic shifts in either direction.
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   start              request, sampled only in IDLE
//   direction          0 = left, 1 = right
//   mode               00 logical, 01 rotate, 10 arithmetic, 11 logical
//   X, shamt           operand and unsigned shift amount
//   busy               high whenever the FSM is not IDLE
//   done               one-cycle completion pulse
//   result             work register, held from DONE until the next accept
//   digits             per-bit display digits of result
module iter_shifter
  import shifter_pkg::*;
#(
  parameter int WIDTH   = 6,
  parameter int SHAMT_W = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 direction,
  input  logic [1:0]           mode,
  input  logic [WIDTH-1:0]     X,
  input  logic [SHAMT_W-1:0]   shamt,
  output logic                 busy,
  output logic                 done,
  output logic [WIDTH-1:0]     result,
  output logic [4*WIDTH-1:0]   digits
);

  state_t             r_state;
  state_t             w_next_state;
  logic [WIDTH-1:0]   r_work;
  logic [SHAMT_W-1:0] r_cnt;
  logic               r_dir;
  logic [1:0]         r_mode;
  logic [WIDTH-1:0]   w_step;
  logic               w_accept;

  assign w_accept = (r_state == IDLE) && start;

  // NOTE: state uses non-blocking assignments so every flop samples the
  // pre-edge values; blocking here would let later statements see new values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  // NOTE: the default assignment first guarantees every path drives
  // w_next_state, so no latch is inferred.
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      IDLE:    if (start) w_next_state = (shamt != '0) ? SHIFT : DONE;
      SHIFT:   if (r_cnt == SHAMT_W'(1)) w_next_state = DONE;
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // One single-bit step of the latched operation. Mode 11 and arithmetic-left
  // both fall through to the plain logical fill.
  always_comb begin
    w_step = r_work;
    if (!r_dir) begin
      w_step = {r_work[WIDTH-2:0], 1'b0};
      if (r_mode == MODE_ROTATE) w_step[0] = r_work[WIDTH-1];
    end else begin
      w_step = {1'b0, r_work[WIDTH-1:1]};
      if (r_mode == MODE_ROTATE)     w_step[WIDTH-1] = r_work[0];
      else if (r_mode == MODE_ARITH) w_step[WIDTH-1] = r_work[WIDTH-1];
    end
  end

  // Operands are captured only on the accept edge, so later input changes
  // cannot disturb an operation in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_work <= '0;
      r_cnt  <= '0;
      r_dir  <= 1'b0;
      r_mode <= MODE_LOGICAL;
    end else if (w_accept) begin
      r_work <= X;
      r_cnt  <= shamt;
      r_dir  <= direction;
      r_mode <= mode;
    end else if (r_state == SHIFT) begin
      r_work <= w_step;
      r_cnt  <= r_cnt - SHAMT_W'(1);
    end
  end

  assign busy   = (r_state != IDLE);
  assign done   = (r_state == DONE);
  assign result = r_work;

  digit_expand #(.WIDTH(WIDTH)) u_digit_expand (
    .i_bits   (r_work),
    .o_digits (digits)
  );

endmodule

// File: tb/tb_iter_shifter.sv
module tb_iter_shifter;

  localparam int W  = 6;
  localparam int SW = 3;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic            direction = 1'b0;
  logic [1:0]      mode = 2'b00;
  logic [W-1:0]    X = '0;
  logic [SW-1:0]   shamt = '0;
  logic            busy;
  logic            done;
  logic [W-1:0]    result;
  logic [4*W-1:0]  digits;

  int checks = 0;
  int errors = 0;

  iter_shifter #(.WIDTH(W), .SHAMT_W(SW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .direction (direction),
    .mode      (mode),
    .X         (X),
    .shamt     (shamt),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .digits    (digits)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Whole-shift reference computed directly from the shift rules.
  function automatic logic [63:0] ref_shift(input logic [63:0] x, input bit dir,
                                            input logic [1:0] md, input int s);
    logic [63:0] mask;
    logic [63:0] sx;
    int r;
    mask = (64'd1 << W) - 64'd1;
    x = x & mask;
    if (md == 2'b01) begin
      r = s % W;
      if (!dir) return ((x << r) | (x >> (W - r))) & mask;
      else      return ((x >> r) | (x << (W - r))) & mask;
    end
    if (md == 2'b10 && dir) begin
      sx = x[W-1] ? (x | ~mask) : x;
      return ($signed(sx) >>> s) & mask;
    end
    if (!dir) return (x << s) & mask;
    return x >> s;
  endfunction

  function automatic logic [4*W-1:0] ref_digits(input logic [W-1:0] r);
    logic [4*W-1:0] d;
    d = '0;
    for (int i = 0; i < W; i++) d[4*i] = r[i];
    return d;
  endfunction

  // Model: remembers the accepted operation and the edge it was accepted on;
  // every output follows from how many edges have elapsed since then.
  int          m_edge = 0;
  bit          m_act = 1'b0;
  int          m_k = 0;
  int          m_s = 0;
  logic [63:0] m_x = '0;
  bit          m_dir = 1'b0;
  logic [1:0]  m_mode = 2'b00;

  function automatic bit model_busy_at(input int n);
    return m_act && ((n - m_k) <= m_s);
  endfunction

  always @(posedge clk) begin
    m_edge = m_edge + 1;
    if (rst_n && start && !model_busy_at(m_edge - 1)) begin
      m_act  = 1'b1;
      m_k    = m_edge;
      m_s    = int'(shamt);
      m_x    = 64'(X);
      m_dir  = direction;
      m_mode = mode;
    end
  end

  always @(negedge rst_n) m_act = 1'b0;

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    int d;
    logic [W-1:0] er;
    d  = m_edge - m_k;
    er = m_act ? W'(ref_shift(m_x, m_dir, m_mode, (d < m_s) ? d : m_s)) : '0;
    check("busy",   64'(busy),   64'(model_busy_at(m_edge)));
    check("done",   64'(done),   64'(m_act && d == m_s));
    check("result", 64'(result), 64'(er));
    check("digits", 64'(digits), 64'(ref_digits(er)));
  end

  // Directed operation with hand-computed expectations.
  task automatic run_op(input string name, input logic [W-1:0] x, input bit dir,
                        input logic [1:0] md, input int sh, input logic [W-1:0] exp);
    int lat;
    @(negedge clk);
    #1;
    X = x; direction = dir; mode = md; shamt = SW'(sh); start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    X = ~x; shamt = SW'(sh + 3); direction = ~dir; mode = ~md;
    lat = 0;
    while (!done && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({name, "_latency"}, 64'(lat), 64'(sh));
    check({name, "_result"},  64'(result), 64'(exp));
    @(posedge clk);
    #1;
    check({name, "_idle"},    64'(busy), 64'd0);
    check({name, "_hold"},    64'(result), 64'(exp));
  endtask

  initial begin
    int lat;
    int done_seen;
    #12;
    check("reset_busy",   64'(busy),   64'd0);
    check("reset_done",   64'(done),   64'd0);
    check("reset_result", 64'(result), 64'd0);
    check("reset_digits", 64'(digits), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("lsl2",  6'b110100, 1'b0, 2'b00, 2, 6'b010000);
    check("lsl2_digits", 64'(digits), 64'h010000);
    run_op("ror2",  6'b110100, 1'b1, 2'b01, 2, 6'b001101);
    run_op("rol7",  6'b110100, 1'b0, 2'b01, 7, 6'b101001);
    run_op("asr3",  6'b110100, 1'b1, 2'b10, 3, 6'b111110);
    run_op("lsl7",  6'b110100, 1'b0, 2'b00, 7, 6'b000000);
    run_op("asl2",  6'b110101, 1'b0, 2'b10, 2, 6'b010100);
    run_op("m11r2", 6'b110101, 1'b1, 2'b11, 2, 6'b001101);
    run_op("asr7",  6'b100000, 1'b1, 2'b10, 7, 6'b111111);

    // shamt = 0: done in the cycle after accept, busy for exactly one cycle.
    @(negedge clk);
    X = 6'b101011; direction = 1'b0; mode = 2'b00; shamt = '0; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("z_done",   64'(done),   64'd1);
    check("z_busy",   64'(busy),   64'd1);
    check("z_result", 64'(result), 64'b101011);
    @(posedge clk);
    #1;
    check("z_busy_after", 64'(busy), 64'd0);

    // start re-asserted mid-SHIFT with new operands is ignored.
    @(negedge clk);
    X = 6'b110100; direction = 1'b1; mode = 2'b00; shamt = 3'd5; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    X = 6'b111111; shamt = 3'd1; direction = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat = 3;
    while (!done && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("ign_latency", 64'(lat), 64'd5);
    check("ign_result",  64'(result), 64'b000001);

    // Reset in the middle of SHIFT: outputs clear at once, no done follows.
    repeat (2) @(posedge clk);
    @(negedge clk);
    X = 6'b011011; direction = 1'b0; mode = 2'b01; shamt = 3'd6; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_busy",   64'(busy),   64'd0);
    check("abort_done",   64'(done),   64'd0);
    check("abort_result", 64'(result), 64'd0);
    check("abort_digits", 64'(digits), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    done_seen = 0;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (done) done_seen++;
    end
    check("abort_no_done", 64'(done_seen), 64'd0);
    run_op("after_rst", 6'b000011, 1'b1, 2'b01, 1, 6'b100001);

    // Randomized traffic with operand churn and occasional mid-cycle resets.
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      #1;
      start     = ($urandom_range(0, 2) == 0);
      direction = 1'($urandom);
      mode      = 2'($urandom);
      X         = W'($urandom);
      shamt     = SW'($urandom);
      if ($urandom_range(0, 149) == 0) begin
        #2;
        rst_n = 1'b0;
        #1;
        check("rnd_rst_busy",   64'(busy),   64'd0);
        check("rnd_rst_result", 64'(result), 64'd0);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
      end
    end

    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
